// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide sequencer.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic [1:0]       hilo_wconfig;
    logic [WIDTH-1:0] hilo_hi;
    logic [WIDTH-1:0] hilo_lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hilo_we, hilo_wconfig, hilo_hi, hilo_lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hilo_we, hilo_wconfig, hilo_hi, hilo_lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EX stage: single-cycle multiply, 32-step restoring divide,
// MTHI/MTLO, with a one-cycle write-back slot that flush can suppress.
module muldiv_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DIV_ITERS);
    localparam int W2 = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_WB   = 3'd4
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  res_hi_q;
    logic [WIDTH-1:0]  res_lo_q;

    logic              op_valid;
    logic              op_sdiv;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;
    logic [WIDTH:0]    trial;
    logic              trial_ge;
    logic [WIDTH:0]    trial_diff;
    logic [WIDTH-1:0]  rem_d;
    logic signed [WIDTH:0]  mul_a;
    logic signed [WIDTH:0]  mul_b;
    logic signed [W2-1:0]   prod;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    assign op_valid     = (bus.op[2:1] != 2'b11);
    assign op_sdiv      = (op_q == OP_DIV);
    assign dividend_mag = ((bus.op == OP_DIV) && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign divisor_mag  = (op_sdiv && b_q[WIDTH-1]) ? -b_q : b_q;

    // Remainder holds in res_hi_q; the dividend shifts out of res_lo_q while quotient bits shift in.
    assign trial      = {res_hi_q, res_lo_q[WIDTH-1]};
    assign trial_ge   = (trial >= {1'b0, divisor_mag});
    assign trial_diff = trial - {1'b0, divisor_mag};
    assign rem_d      = trial_ge ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];

    assign mul_a = $signed({(op_q == OP_MULT) & a_q[WIDTH-1], a_q});
    assign mul_b = $signed({(op_q == OP_MULT) & b_q[WIDTH-1], b_q});
    assign prod  = W2'(mul_a) * W2'(mul_b);

    // Overflow (most-negative / -1) needs no special case: the magnitude quotient already is 0x80000000.
    assign quo_fix = (op_sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -res_lo_q : res_lo_q;
    assign rem_fix = (op_sdiv && a_q[WIDTH-1]) ? -res_hi_q : res_hi_q;

    // Sequencer state, captured operands, divide counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'd0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else if ((state_q != S_IDLE) && bus.flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.flush && op_valid) begin
                        a_q  <= bus.a;
                        b_q  <= bus.b;
                        op_q <= bus.op;
                        case (bus.op)
                            OP_MTHI: begin
                                res_hi_q <= bus.a;
                                state_q  <= S_WB;
                            end
                            OP_MTLO: begin
                                res_lo_q <= bus.a;
                                state_q  <= S_WB;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.b == '0) begin
                                    res_hi_q <= bus.a;
                                    res_lo_q <= '1;
                                    state_q  <= S_WB;
                                end else begin
                                    res_hi_q <= '0;
                                    res_lo_q <= dividend_mag;
                                    cnt_q    <= '0;
                                    state_q  <= S_DIV;
                                end
                            end
                            default: state_q <= S_MUL;
                        endcase
                    end
                end
                S_MUL: begin
                    {res_hi_q, res_lo_q} <= prod;
                    state_q <= S_WB;
                end
                S_DIV: begin
                    res_hi_q <= rem_d;
                    res_lo_q <= {res_lo_q[WIDTH-2:0], trial_ge};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DIV_ITERS - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    res_lo_q <= quo_fix;
                    res_hi_q <= rem_fix;
                    state_q  <= S_WB;
                end
                S_WB:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write port and status, decoded from the state register; flush kills the write in WB.
    always_comb begin
        bus.busy         = (state_q != S_IDLE);
        bus.hilo_hi      = res_hi_q;
        bus.hilo_lo      = res_lo_q;
        bus.hilo_we      = 1'b0;
        bus.done         = 1'b0;
        bus.hilo_wconfig = 2'b00;
        if (state_q == S_WB) begin
            bus.hilo_we = ~bus.flush;
            bus.done    = ~bus.flush;
            case (op_q)
                OP_MTHI: bus.hilo_wconfig = 2'b10;
                OP_MTLO: bus.hilo_wconfig = 2'b01;
                default: bus.hilo_wconfig = 2'b11;
            endcase
        end else begin
            bus.hilo_we      = 1'b0;
            bus.hilo_wconfig = 2'b00;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected write-back cycle, write mask and HI/LO from plain arithmetic; lat=0 means ignored.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [1:0] cfg,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint p;
        longint q;
        longint r;
        lat = 0; cfg = 2'b00; hi = 32'd0; lo = 32'd0;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32]; lo = p[31:0]; lat = 2; cfg = 2'b11;
            end
            3'd1: begin
                p = longint'({32'd0, a}) * longint'({32'd0, b});
                hi = p[63:32]; lo = p[31:0]; lat = 2; cfg = 2'b11;
            end
            3'd2, 3'd3: begin
                cfg = 2'b11;
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 1;
                end else begin
                    if (op == 3'd2) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    lo = q[31:0]; hi = r[31:0]; lat = 34;
                end
            end
            3'd4: begin hi = a; lat = 1; cfg = 2'b10; end
            3'd5: begin lo = a; lat = 1; cfg = 2'b01; end
            default: lat = 0;
        endcase
    endtask

    // Issue one request; flush_at>0 raises flush in that cycle; hold keeps start high with junk while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit hold);
        int lat;
        int last;
        logic [1:0] cfg;
        logic [31:0] hi;
        logic [31:0] lo;
        bit wr;
        ref_op(op, a, b, lat, cfg, hi, lo);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        if (lat == 0) begin
            #1 bus.start = 1'b0;
            #1;
            check_eq("rsv_busy", 64'(bus.busy), 64'd0);
            check_eq("rsv_we", 64'(bus.hilo_we), 64'd0);
            return;
        end
        last = (flush_at > 0 && flush_at <= lat) ? flush_at : lat;
        for (int c = 1; c <= last; c++) begin
            #1;
            bus.flush = (c == flush_at);
            if (!hold || c == last) begin
                bus.start = 1'b0;
            end else begin
                bus.op = 3'($urandom_range(0, 5)); bus.a = $urandom; bus.b = $urandom;
            end
            #1;
            wr = (c == lat) && (c != flush_at);
            check_eq("busy", 64'(bus.busy), 64'd1);
            check_eq("we", 64'(bus.hilo_we), 64'(wr));
            check_eq("done", 64'(bus.done), 64'(wr));
            if (wr) begin
                check_eq("wcfg", 64'(bus.hilo_wconfig), 64'(cfg));
                if (cfg[1]) check_eq("hi", 64'(bus.hilo_hi), 64'(hi));
                if (cfg[0]) check_eq("lo", 64'(bus.hilo_lo), 64'(lo));
            end
            @(posedge clk);
        end
        #1 bus.flush = 1'b0; bus.start = 1'b0;
        #1;
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        check_eq("idle_we", 64'(bus.hilo_we), 64'd0);
    endtask

    function automatic logic [31:0] pick_val(input int sel);
        case (sel)
            0: pick_val = 32'h8000_0000;
            1: pick_val = 32'hFFFF_FFFF;
            2: pick_val = 32'd0;
            3: pick_val = 32'($urandom_range(1, 200));
            default: pick_val = $urandom;
        endcase
    endfunction

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_we", 64'(bus.hilo_we), 64'd0);
        check_eq("rst_wcfg", 64'(bus.hilo_wconfig), 64'd0);
        check_eq("rst_hilo", {bus.hilo_hi, bus.hilo_lo}, 64'd0);
        rst = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        run_op(3'd3, 32'd100, 32'd7, 0, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(3'd4, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 0, 1'b0);
        run_op(3'd2, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
        run_op(3'd3, 32'hFFFF_0000, 32'd3, 10, 1'b0);
        run_op(3'd1, 32'h0001_0003, 32'h0002_0005, 0, 1'b0);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 2, 1'b0);
        run_op(3'd2, 32'd77, 32'hFFFF_FFF6, 0, 1'b1);
        run_op(3'd6, 32'd1, 32'd1, 0, 1'b0);
        run_op(3'd7, 32'd1, 32'd1, 0, 1'b0);

        // Flush in IDLE must block acceptance.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.flush = 1'b0;
        #1 check_eq("idle_flush_busy", 64'(bus.busy), 64'd0);

        // Reset in cycle 15 of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'h0F0F_0F0F; bus.b = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_we", 64'({bus.hilo_we, bus.done, bus.hilo_wconfig}), 64'd0);
        check_eq("mid_rst_hilo", {bus.hilo_hi, bus.hilo_lo}, 64'd0);

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_val($urandom_range(0, 7)),
                   pick_val($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 35)) : 0,
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns all writes to the HI/LO register pair in the MIPS execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, computes the result (1-cycle multiply, 32-iteration restoring divide), and drives the HI/LO write port (we, 2-bit wconfig {hi,lo}, hi/lo data). Asserts busy to stall the pipeline while an operation is in flight.

Parameters:
DIV_ITERS, 32, divide iterations (equals data width; do not change independently of WIDTH)
WIDTH, 32, operand width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  operation request from EX; sampled only in IDLE
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
a  in  32  rs value (dividend / multiplicand / MTHI, MTLO source)
b  in  32  rt value (divisor / multiplier)
flush  in  1  exception/flush; aborts in-flight operation
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in WB when the write is not suppressed
hilo_we  out  1  HI/LO write enable
hilo_wconfig  out  2  bit1 = write HI, bit0 = write LO
hilo_hi  out  32  HI write data
hilo_lo  out  32  LO write data

Behaviour:
- States: IDLE, MUL, DIV, FIX, WB. Reset -> IDLE; result regs, counter and operand regs cleared to 0.
- Reset outputs: busy=0, done=0, hilo_we=0, hilo_wconfig=00, hilo_hi=0, hilo_lo=0.
- IDLE, start=1, op valid: capture a, b, op.
  - MTHI -> WB, result_hi=a.
  - MTLO -> WB, result_lo=a.
  - MULT/MULTU -> MUL.
  - DIV/DIVU with b!=0 -> DIV, counter=0.
  - DIV/DIVU with b==0 -> WB, result_lo=0xFFFFFFFF, result_hi=a.
- IDLE, start=1, op 6/7: ignored; stay in IDLE.
- start while busy: ignored. The requester holds the instruction under stall.
- MUL: one cycle. Full 64-bit product: signed for MULT, unsigned for MULTU. Registered as {result_hi,result_lo}. -> WB.
- DIV: restoring divide on magnitudes.
  - Magnitudes: |a|, |b| for DIV; raw values for DIVU.
  - One quotient bit per cycle, MSB first. Counter 0..31.
  - After iteration 31 -> FIX.
- FIX: one cycle applying signs (DIV only; DIVU passes through).
  - Quotient negated iff a[31]^b[31].
  - Remainder takes the sign of a.
  - LO=quotient, HI=remainder. -> WB.
  - Overflow case 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- WB: one cycle, then -> IDLE.
  - hilo_we = ~flush, combinational from state. done = ~flush.
  - hilo_wconfig: 10 for MTHI, 01 for MTLO, 11 for mul/div.
  - Outside WB: hilo_we=0 and wconfig=00.
  - hilo_hi/hilo_lo always reflect the result regs.
- Latency (start sampled at cycle 0):
  - MTHI/MTLO/div-by-zero: WB in cycle 1.
  - MUL: WB in cycle 2.
  - DIV/DIVU: DIV cycles 1–32, FIX cycle 33, WB cycle 34.
- flush in any non-IDLE state: next state IDLE, no HI/LO write. Flush during WB suppresses hilo_we that same cycle.
- flush in IDLE with start=1: request is not accepted.
- rst has priority over flush and start, from any state. It returns to IDLE with outputs at reset values next cycle.
- busy=1 from cycle 1 through WB inclusive; 0 the cycle after WB.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 -> cycle 2: we=1, wconfig=11, HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIVU a=100 b=7 -> busy cycles 1–34, WB at cycle 34: LO=0x0000000E, HI=0x00000002, done pulse exactly 1 cycle.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> wconfig 10 then 01 with correct data, each WB 1 cycle after start. DIV by b=0 -> cycle 1: LO=0xFFFFFFFF, HI=a.
- DIVU started, flush at cycle 10 -> IDLE at cycle 11, hilo_we never asserted. A new MULTU immediately after completes correctly. Flush coincident with WB -> no write, no done.
- rst asserted mid-DIV (cycle 15) -> next cycle all outputs 0, busy=0. start during busy is ignored: result matches the first op only.
